// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage: ALU command codes, shift types,
// NZCV bit positions and a rotate helper.
package exe_pkg;

    // ALU command encodings carried by exe_cmd_in
    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;

    // Register-operand shift types (shift_operand[6:5])
    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    // Bit positions inside the {N,Z,C,V} status vector
    localparam int N_IDX = 3;
    localparam int Z_IDX = 2;
    localparam int C_IDX = 1;
    localparam int V_IDX = 0;

    // Rotate a 32-bit word right by 0..31 places
    function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] doubled;
        doubled = {x, x} >> n;
        return doubled[31:0];
    endfunction

endpackage

// File: rtl/val2_gen.sv
// Second-operand generator: rotated 8-bit immediate, 12-bit memory offset,
// or shifted register value.
module val2_gen
    import exe_pkg::*;
(
    input  logic        imm,
    input  logic        mem_access,
    input  logic [11:0] shift_operand,
    input  logic [31:0] rm,
    output logic [31:0] val2
);

    logic [4:0] amount;
    logic [4:0] rot;

    assign amount = shift_operand[11:7];
    assign rot    = {shift_operand[11:8], 1'b0};

    // Select and shape Val2 from the three possible sources
    always_comb begin
        // NOTE: default first so every path assigns val2 and no latch is inferred.
        val2 = rm;
        if (imm) begin
            val2 = ror32({24'b0, shift_operand[7:0]}, rot);
        end else if (mem_access) begin
            val2 = {20'b0, shift_operand};
        end else begin
            case (shift_operand[6:5])
                SH_LSL:  val2 = rm << amount;
                SH_LSR:  val2 = rm >> amount;
                SH_ASR:  val2 = $signed(rm) >>> amount;
                SH_ROR:  val2 = ror32(rm, amount);
                default: val2 = rm;
            endcase
        end
    end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand selection, ALU, NZCV status register, branch target
// and the EXE/MEM output register. Define EXE_FWD_EN to add operand
// forwarding from MEM and WB.
module exe_stage
    import exe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_en_in,
    input  logic        mem_r_en_in,
    input  logic        mem_w_en_in,
    input  logic        b_in,
    input  logic        s_in,
    input  logic [3:0]  exe_cmd_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] val_rn_in,
    input  logic [31:0] val_rm_in,
    input  logic        imm_in,
    input  logic [11:0] shift_operand_in,
    input  logic [23:0] signed_imm_24_in,
    input  logic [3:0]  dest_in,
`ifdef EXE_FWD_EN
    input  logic [1:0]  sel_src1,
    input  logic [1:0]  sel_src2,
    input  logic [31:0] mem_fwd_val,
    input  logic [31:0] wb_fwd_val,
`endif
    output logic        wb_en,
    output logic        mem_r_en,
    output logic        mem_w_en,
    output logic [31:0] alu_res,
    output logic [31:0] st_val,
    output logic [3:0]  dest,
    output logic        branch_taken,
    output logic [31:0] branch_addr,
    output logic [3:0]  status
);

    logic [31:0] op1;
    logic [31:0] op2_rm;
    logic [31:0] val2;
    logic [31:0] alu_out;
    logic [32:0] sum;
    logic        c_next;
    logic        v_next;
    logic        cmd_known;
    logic [3:0]  status_next;

`ifdef EXE_FWD_EN
    // Pick each operand from the register file or a forwarding path
    always_comb begin
        case (sel_src1)
            2'b01:   op1 = mem_fwd_val;
            2'b10:   op1 = wb_fwd_val;
            default: op1 = val_rn_in;
        endcase
        case (sel_src2)
            2'b01:   op2_rm = mem_fwd_val;
            2'b10:   op2_rm = wb_fwd_val;
            default: op2_rm = val_rm_in;
        endcase
    end
`else
    assign op1    = val_rn_in;
    assign op2_rm = val_rm_in;
`endif

    val2_gen u_val2_gen (
        .imm           (imm_in),
        .mem_access    (mem_r_en_in | mem_w_en_in),
        .shift_operand (shift_operand_in),
        .rm            (op2_rm),
        .val2          (val2)
    );

    // ALU result and the carry/overflow each command would produce
    always_comb begin
        alu_out   = '0;
        sum       = '0;
        c_next    = status[C_IDX];
        v_next    = status[V_IDX];
        cmd_known = 1'b1;
        case (exe_cmd_in)
            CMD_MOV: alu_out = val2;
            CMD_MVN: alu_out = ~val2;
            CMD_ADD, CMD_ADC: begin
                sum     = {1'b0, op1} + {1'b0, val2}
                        + {32'b0, (exe_cmd_in == CMD_ADC) & status[C_IDX]};
                alu_out = sum[31:0];
                c_next  = sum[32];
                v_next  = (op1[31] == val2[31]) && (alu_out[31] != op1[31]);
            end
            CMD_SUB, CMD_SBC: begin
                // Subtract as Rn + ~Val2 + carry-in; the carry-out is NOT borrow
                sum     = {1'b0, op1} + {1'b0, ~val2}
                        + {32'b0, (exe_cmd_in == CMD_SUB) | status[C_IDX]};
                alu_out = sum[31:0];
                c_next  = sum[32];
                v_next  = (op1[31] != val2[31]) && (alu_out[31] != op1[31]);
            end
            CMD_AND: alu_out = op1 & val2;
            CMD_ORR: alu_out = op1 | val2;
            CMD_EOR: alu_out = op1 ^ val2;
            default: cmd_known = 1'b0;
        endcase
        status_next = cmd_known ? {alu_out[31], (alu_out == 32'd0), c_next, v_next} : status;
    end

    assign branch_taken = b_in;
    assign branch_addr  = pc_in + {{6{signed_imm_24_in[23]}}, signed_imm_24_in, 2'b00};

    // EXE/MEM register and status flags, synchronously cleared by rst
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            wb_en    <= 1'b0;
            mem_r_en <= 1'b0;
            mem_w_en <= 1'b0;
            alu_res  <= '0;
            st_val   <= '0;
            dest     <= '0;
            status   <= '0;
        end else begin
            wb_en    <= wb_en_in;
            mem_r_en <= mem_r_en_in;
            mem_w_en <= mem_w_en_in;
            alu_res  <= alu_out;
            st_val   <= op2_rm;
            dest     <= dest_in;
            if (s_in) begin
                status <= status_next;
            end
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: the driver applies directed vectors on the
// falling edge and queues the hand-computed response; the monitor compares
// just after each rising edge. Define EXE_FWD_EN to add the forwarding vector.
`timescale 1ns/1ps
module tb_exe_stage;
    import exe_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in;
    logic [3:0]  exe_cmd_in;
    logic [31:0] pc_in, val_rn_in, val_rm_in;
    logic        imm_in;
    logic [11:0] shift_operand_in;
    logic [23:0] signed_imm_24_in;
    logic [3:0]  dest_in;
`ifdef EXE_FWD_EN
    logic [1:0]  sel_src1, sel_src2;
    logic [31:0] mem_fwd_val, wb_fwd_val;
`endif
    logic        wb_en, mem_r_en, mem_w_en;
    logic [31:0] alu_res, st_val;
    logic [3:0]  dest;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [3:0]  status;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       name;
        logic        wb, mr, mw;
        logic [31:0] res, st;
        logic [3:0]  dst, stat;
        logic        bt;
        logic [31:0] ba;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    exe_stage dut (
        .clk              (clk),
        .rst              (rst),
        .wb_en_in         (wb_en_in),
        .mem_r_en_in      (mem_r_en_in),
        .mem_w_en_in      (mem_w_en_in),
        .b_in             (b_in),
        .s_in             (s_in),
        .exe_cmd_in       (exe_cmd_in),
        .pc_in            (pc_in),
        .val_rn_in        (val_rn_in),
        .val_rm_in        (val_rm_in),
        .imm_in           (imm_in),
        .shift_operand_in (shift_operand_in),
        .signed_imm_24_in (signed_imm_24_in),
        .dest_in          (dest_in),
`ifdef EXE_FWD_EN
        .sel_src1         (sel_src1),
        .sel_src2         (sel_src2),
        .mem_fwd_val      (mem_fwd_val),
        .wb_fwd_val       (wb_fwd_val),
`endif
        .wb_en            (wb_en),
        .mem_r_en         (mem_r_en),
        .mem_w_en         (mem_w_en),
        .alu_res          (alu_res),
        .st_val           (st_val),
        .dest             (dest),
        .branch_taken     (branch_taken),
        .branch_addr      (branch_addr),
        .status           (status)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Set the ALU-related inputs and clear everything else to a bubble
    task automatic set_op(input logic [3:0] cmd, input logic s, input logic imm,
                          input logic [11:0] so, input logic [31:0] rn, input logic [31:0] rm);
        rst              = 1'b0;
        wb_en_in         = 1'b0;
        mem_r_en_in      = 1'b0;
        mem_w_en_in      = 1'b0;
        b_in             = 1'b0;
        s_in             = s;
        exe_cmd_in       = cmd;
        pc_in            = '0;
        val_rn_in        = rn;
        val_rm_in        = rm;
        imm_in           = imm;
        shift_operand_in = so;
        signed_imm_24_in = '0;
        dest_in          = '0;
`ifdef EXE_FWD_EN
        sel_src1         = 2'b00;
        sel_src2         = 2'b00;
        mem_fwd_val      = '0;
        wb_fwd_val       = '0;
`endif
    endtask

    task automatic push(input string name, input logic wb, input logic mr, input logic mw,
                        input logic [31:0] res, input logic [31:0] st, input logic [3:0] dst,
                        input logic [3:0] stat, input logic bt, input logic [31:0] ba);
        exp_t e;
        e.name = name; e.wb = wb; e.mr = mr; e.mw = mw; e.res = res; e.st = st;
        e.dst = dst; e.stat = stat; e.bt = bt; e.ba = ba;
        exp_q.push_back(e);
    endtask

    // Monitor: registered outputs are settled 1 ns after the rising edge,
    // and the driver holds the inputs until the following falling edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.name, ".wb_en"},        {31'b0, wb_en},        {31'b0, e.wb});
                check({e.name, ".mem_r_en"},     {31'b0, mem_r_en},     {31'b0, e.mr});
                check({e.name, ".mem_w_en"},     {31'b0, mem_w_en},     {31'b0, e.mw});
                check({e.name, ".alu_res"},      alu_res,               e.res);
                check({e.name, ".st_val"},       st_val,                e.st);
                check({e.name, ".dest"},         {28'b0, dest},         {28'b0, e.dst});
                check({e.name, ".status"},       {28'b0, status},       {28'b0, e.stat});
                check({e.name, ".branch_taken"}, {31'b0, branch_taken}, {31'b0, e.bt});
                check({e.name, ".branch_addr"},  branch_addr,           e.ba);
            end
        end
    end

    // Driver: one vector per cycle, expectations hand-computed
    initial begin
        set_op(4'b0000, 1'b0, 1'b0, 12'h000, 32'h0, 32'h0);
        rst = 1'b1;

        // reset overrides a concurrent flag update
        @(negedge clk); set_op(CMD_ADD, 1, 1, 12'h001, 32'h7FFFFFFF, 32'h0); rst = 1'b1; wb_en_in = 1'b1;
        push("reset", 0, 0, 0, 32'h0, 32'h0, 4'h0, 4'b0000, 0, 32'h0);

        @(negedge clk); set_op(CMD_ADD, 1, 1, 12'h001, 32'h7FFFFFFF, 32'h0); wb_en_in = 1'b1; dest_in = 4'd3;
        push("add_ovf", 1, 0, 0, 32'h80000000, 32'h0, 4'd3, 4'b1001, 0, 32'h0);

        @(negedge clk); set_op(CMD_SUB, 1, 0, 12'h000, 32'd5, 32'd5); wb_en_in = 1'b1; dest_in = 4'd4;
        push("sub_zero", 1, 0, 0, 32'h0, 32'd5, 4'd4, 4'b0110, 0, 32'h0);

        @(negedge clk); set_op(CMD_MOV, 0, 1, 12'h4FF, 32'h0, 32'h0);
        push("mov_rot", 0, 0, 0, 32'hFF000000, 32'h0, 4'h0, 4'b0110, 0, 32'h0);

        @(negedge clk); set_op(CMD_ADC, 1, 1, 12'h002, 32'd1, 32'h0);
        push("adc_c1", 0, 0, 0, 32'd4, 32'h0, 4'h0, 4'b0000, 0, 32'h0);

        @(negedge clk); set_op(CMD_SBC, 1, 1, 12'h003, 32'd10, 32'h0);
        push("sbc_c0", 0, 0, 0, 32'd6, 32'h0, 4'h0, 4'b0010, 0, 32'h0);

        @(negedge clk); set_op(CMD_MOV, 0, 0, 12'h220, 32'h0, 32'h80000001);
        push("lsr4", 0, 0, 0, 32'h08000000, 32'h80000001, 4'h0, 4'b0010, 0, 32'h0);

        @(negedge clk); set_op(CMD_MOV, 0, 0, 12'h240, 32'h0, 32'h80000001);
        push("asr4", 0, 0, 0, 32'hF8000000, 32'h80000001, 4'h0, 4'b0010, 0, 32'h0);

        @(negedge clk); set_op(CMD_MOV, 0, 0, 12'h260, 32'h0, 32'h80000001);
        push("ror4", 0, 0, 0, 32'h18000000, 32'h80000001, 4'h0, 4'b0010, 0, 32'h0);

        @(negedge clk); set_op(CMD_ORR, 1, 0, 12'h200, 32'hF0F00000, 32'h00000F0F);
        push("orr_lsl4", 0, 0, 0, 32'hF0F0F0F0, 32'h00000F0F, 4'h0, 4'b1010, 0, 32'h0);

        @(negedge clk); set_op(CMD_EOR, 1, 0, 12'h000, 32'hFFFF0000, 32'hFFFF0000);
        push("eor_zero", 0, 0, 0, 32'h0, 32'hFFFF0000, 4'h0, 4'b0110, 0, 32'h0);

        @(negedge clk); set_op(CMD_MVN, 1, 1, 12'h000, 32'h0, 32'h0);
        push("mvn", 0, 0, 0, 32'hFFFFFFFF, 32'h0, 4'h0, 4'b1010, 0, 32'h0);

        @(negedge clk); set_op(4'b0000, 1, 0, 12'h000, 32'd5, 32'd5);
        push("undef_cmd", 0, 0, 0, 32'h0, 32'd5, 4'h0, 4'b1010, 0, 32'h0);

        @(negedge clk); set_op(CMD_AND, 0, 1, 12'h0FF, 32'h123456F7, 32'h0);
        push("and_imm", 0, 0, 0, 32'h000000F7, 32'h0, 4'h0, 4'b1010, 0, 32'h0);

        @(negedge clk); set_op(4'b0000, 0, 0, 12'h000, 32'h0, 32'h0);
        b_in = 1'b1; pc_in = 32'h100; signed_imm_24_in = 24'hFFFFFE;
        push("branch_back", 0, 0, 0, 32'h0, 32'h0, 4'h0, 4'b1010, 1, 32'h000000F8);

        @(negedge clk); set_op(4'b0000, 0, 0, 12'h000, 32'h0, 32'h0);
        pc_in = 32'hFFFFFFFC; signed_imm_24_in = 24'h000002;
        push("branch_wrap", 0, 0, 0, 32'h0, 32'h0, 4'h0, 4'b1010, 0, 32'h00000004);

        @(negedge clk); set_op(CMD_ADD, 0, 0, 12'h804, 32'h1000, 32'h0);
        mem_r_en_in = 1'b1; wb_en_in = 1'b1; dest_in = 4'd7;
        push("ldr", 1, 1, 0, 32'h1804, 32'h0, 4'd7, 4'b1010, 0, 32'h0);

        @(negedge clk); rst = 1'b1;
        push("ldr_reset", 0, 0, 0, 32'h0, 32'h0, 4'h0, 4'b0000, 0, 32'h0);

        @(negedge clk); rst = 1'b0;
        push("ldr_after_reset", 1, 1, 0, 32'h1804, 32'h0, 4'd7, 4'b0000, 0, 32'h0);

        @(negedge clk); set_op(CMD_ADD, 0, 0, 12'h010, 32'h2000, 32'hDEADBEEF); mem_w_en_in = 1'b1;
        push("str", 0, 0, 1, 32'h2010, 32'hDEADBEEF, 4'h0, 4'b0000, 0, 32'h0);

        @(negedge clk); set_op(CMD_SUB, 1, 1, 12'h001, 32'h80000000, 32'h0);
        push("sub_ovf", 0, 0, 0, 32'h7FFFFFFF, 32'h0, 4'h0, 4'b0011, 0, 32'h0);

`ifdef EXE_FWD_EN
        @(negedge clk); set_op(CMD_ADD, 0, 1, 12'h003, 32'h0, 32'h0);
        sel_src1 = 2'b01; mem_fwd_val = 32'd7; sel_src2 = 2'b10; wb_fwd_val = 32'h0000ABCD;
        push("fwd_add", 0, 0, 0, 32'd10, 32'h0000ABCD, 4'h0, 4'b0011, 0, 32'h0);
`endif

        @(negedge clk); set_op(4'b0000, 0, 0, 12'h000, 32'h0, 32'h0);

        // Bounded wait for the monitor to drain the scoreboard
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 clk  in  1  rising-edge clock; all state updates on posedge.
REQ-002 rst  in  1  reset, synchronous, active-high; clock clk.
REQ-003 wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in  in  1 each  control bits from the ID/EXE register.
REQ-004 exe_cmd_in  in  4  ALU command.
REQ-005 pc_in  in  32  PC+4 of the instruction in EXE.
REQ-006 val_rn_in, val_rm_in  in  32 each  register operands.
REQ-007 imm_in  in  1; shift_operand_in  in  12  Val2 source selection and fields.
REQ-008 signed_imm_24_in  in  24  branch offset in words.
REQ-009 dest_in  in  4  destination register.
REQ-010 sel_src1, sel_src2  in  2 each; mem_fwd_val, wb_fwd_val  in  32 each  forwarding selects and values (EXE_FWD_EN only).
REQ-011 wb_en, mem_r_en, mem_w_en  out  1 each  registered control to MEM.
REQ-012 alu_res  out  32  registered ALU result / memory address.
REQ-013 st_val  out  32  registered store data (forwarded Rm).
REQ-014 dest  out  4  registered destination.
REQ-015 branch_taken  out  1 (combinational = b_in); branch_addr  out  32 (combinational).
REQ-016 status  out  4  registered NZCV {N,Z,C,V}, fed back to the ID condition check.

Function
REQ-017 exe_cmd encoding: MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000; others -> result 0, flags unchanged.
REQ-018 Val2 when imm_in=1: zero-extended shift_operand_in[7:0] rotated right by 2*shift_operand_in[11:8].
REQ-019 Val2 when imm_in=0 and (mem_r_en_in|mem_w_en_in): zero-extended shift_operand_in[11:0].
REQ-020 Val2 otherwise: Rm shifted by shift_operand_in[11:7]; type [6:5] = LSL 00, LSR 01, ASR 10, ROR 11; amount 0 passes Rm unchanged.
REQ-021 ADC = Rn+Val2+C; SBC = Rn-Val2-(~C); C/V are taken from the status register before this cycle's update.
REQ-022 N=res[31], Z=(res==0); add ops: C=carry-out of 33-bit sum, V=signed overflow; sub ops: C=NOT borrow, V=signed overflow; MOV/MVN/AND/ORR/EOR keep C and V.
REQ-023 status updates at the posedge only when s_in=1; s_in=0 holds status.
REQ-024 branch_addr = pc_in + (sign-extended signed_imm_24_in << 2), mod 2^32 wrap.
REQ-025 Output registers load every posedge: latency exactly 1 cycle from inputs to wb_en..dest.
REQ-026 Upstream flush inserts zeroed control bits; these pass through as a bubble, and status holds because s_in=0.

Reset
REQ-027 rst=1 at posedge: wb_en, mem_r_en, mem_w_en, alu_res, st_val, dest, status all 0, overriding any concurrent s_in update.
REQ-028 Reset mid-operation discards the in-flight result; the first post-reset cycle computes from current inputs.

Configuration
REQ-029 EXE_FWD_EN defined: operand 1 = {val_rn_in, mem_fwd_val, wb_fwd_val} for sel_src1 = {00, 01, 10}, and the same mapping applies to Rm via sel_src2 (11 -> 00 behaviour).
REQ-030 EXE_FWD_EN undefined: forwarding ports are absent and operands are val_rn_in/val_rm_in directly.

Structure
REQ-031 Shared package exe_pkg: exe_cmd constants, shift-type constants, NZCV bit indices.
REQ-032 Sub-module val2_gen: combinational Val2 generation (REQ-018..020); ALU, status register and output registers stay in exe_stage.

Verification
REQ-033 ADD, s=1, Rn=0x7FFFFFFF, Val2 via imm 0x01 -> alu_res=0x80000000, status=1001 next cycle.
REQ-034 SUB, s=1, Rn=5, Rm=5, LSL 0 -> alu_res=0, status=0110.
REQ-035 MOV, imm_in=1, shift_operand=0x4FF (rot 8) -> alu_res=0xFF000000; status unchanged with s=0.
REQ-036 b_in=1, pc_in=0x100, offset=0xFFFFFE -> branch_taken=1, branch_addr=0x000000F8.
REQ-037 LDR, shift_operand=0x804, Rn=0x1000 -> alu_res=0x1804, mem_r_en=1; rst asserted next cycle -> all outputs 0.
REQ-038 EXE_FWD_EN, sel_src1=01, mem_fwd_val=7, ADD with imm 3 -> alu_res=10.
